// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared types and helpers for the fixed-point multiplier datapath
package fxp_pkg;

    // Default operand width and the matching full-product width
    localparam int DEF_DATA_W = 16;
    localparam int PROD_W     = 2 * DEF_DATA_W;

    // Per-beat arithmetic modes, captured at acceptance and carried down the pipe
    typedef struct packed {
        logic rnd;
        logic sat;
    } fxp_mode_t;

    // Largest signed value representable in data_w bits, zero-extended to 32 bits
    function automatic logic [31:0] fxp_max(input int data_w);
        logic [32:0] v;
        v = (33'd1 << (data_w - 1)) - 33'd1;
        return v[31:0];
    endfunction

    // Most negative signed value in data_w bits, as a data_w-bit pattern in 32 bits
    function automatic logic [31:0] fxp_min(input int data_w);
        logic [32:0] v;
        v = 33'd1 << (data_w - 1);
        return v[31:0];
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - round, shift, range-check and saturate a full-width product
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic [2*DATA_W-1:0] prod,
    input  fxp_mode_t           mode,
    output logic [DATA_W-1:0]   data,
    output logic                ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int RW = PW + 1;
    // Half an output LSB; zero when there are no fraction bits to round away
    localparam logic [RW-1:0] RND_ADD =
        (FRAC_W > 0) ? (RW'(1) << ((FRAC_W > 0) ? FRAC_W - 1 : 0)) : '0;
    localparam logic [31:0] MAX_V = fxp_max(DATA_W);
    localparam logic [31:0] MIN_V = fxp_min(DATA_W);

    logic signed [RW-1:0]     r;
    logic signed [RW-1:0]     q;
    logic        [RW-DATA_W:0] top;

    // Quantise the product: optional half-up rounding, floor shift, then clip or wrap
    always_comb begin
        r    = {prod[PW-1], prod} + (mode.rnd ? RND_ADD : '0);
        q    = r >>> FRAC_W;
        // In range exactly when every bit above the result sign bit matches it
        top  = q[RW-1:DATA_W-1];
        ovf  = !((&top) || !(|top));
        data = q[DATA_W-1:0];
        if (mode.sat && ovf) begin
            data = q[RW-1] ? MIN_V[DATA_W-1:0] : MAX_V[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - three-stage signed fixed-point multiplier with valid/ready flow control
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_rnd,
    input  logic              in_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    localparam int PW = 2 * DATA_W;

    logic              v1, v2, v3;
    logic              adv1, adv2, adv3;
    logic [DATA_W-1:0] a1, b1;
    fxp_mode_t         m1, m2;
    logic [PW-1:0]     p2;
    logic [DATA_W-1:0] rs_data;
    logic              rs_ovf;

    // A stage moves when it is empty or its successor moves, so bubbles collapse
    always_comb begin
        adv3     = !v3 || out_ready;
        adv2     = !v2 || adv3;
        adv1     = !v1 || adv2;
        in_ready = adv1;
    end

    // Stage 1: capture operands and this beat's modes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            m1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1 <= in_a;
                b1 <= in_b;
                m1 <= '{rnd: in_rnd, sat: in_sat};
            end
        end
    end

    // Stage 2: full-width signed product, modes follow the operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            p2 <= '0;
            m2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                p2 <= PW'($signed(a1)) * PW'($signed(b1));
                m2 <= m1;
            end
        end
    end

    fxp_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .prod (p2),
        .mode (m2),
        .data (rs_data),
        .ovf  (rs_ovf)
    );

    // Stage 3: registered quantised result and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3       <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                out_data <= rs_data;
                out_ovf  <= rs_ovf;
            end
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - randomized and directed self-checking bench for fxp_mult_pipe
module tb_fxp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_rnd = 1'b0;
    logic        in_sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [16:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [16:0] prev_out = '0;

    fxp_mult_pipe #(.DATA_W(16), .FRAC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rnd    (in_rnd),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Q8.8 product from plain integer arithmetic, returns {ovf, data}
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic r, input logic s);
        longint p;
        longint q;
        logic   o;
        logic [15:0] d;
        p = longint'($signed(a)) * longint'($signed(b));
        if (r) p = p + 128;
        q = p >>> 8;
        o = (q > 32767) || (q < -32768);
        d = q[15:0];
        if (s && o) d = (q < 0) ? 16'h8000 : 16'h7fff;
        return {o, d};
    endfunction

    // Offer one beat, wait (bounded) until accepted, queue its expected result
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic r,
                        input logic s, input logic [16:0] exp);
        int t;
        in_a = a; in_b = b; in_rnd = r; in_sat = s; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (in_ready) exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic r, input logic s);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        send(a, b, r, s, model(a, b, r, s));
    endtask

    // Scoreboard, ready invariant and stall-stability monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 3) || out_ready));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_ovf, out_data}), 32'(prev_out));
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_ovf, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(e[15:0]));
                    check("ovf", 32'(out_ovf), 32'(e[16]));
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic product and accept-to-valid latency
        send(16'h0180, 16'h0200, 1'b0, 1'b0, {1'b0, 16'h0300});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("latency", 32'(out_valid), 32'(k == 2));
        end
        @(posedge clk); #1;
        send(16'hFF00, 16'h0080, 1'b0, 1'b0, {1'b0, 16'hFF80});

        // Rounding and overflow corners with spec-given answers
        send(16'h0001, 16'h0080, 1'b0, 1'b0, {1'b0, 16'h0000});
        send(16'h0001, 16'h0080, 1'b1, 1'b0, {1'b0, 16'h0001});
        send(16'hFFFF, 16'h0080, 1'b0, 1'b0, {1'b0, 16'hFFFF});
        send(16'hFFFF, 16'h0080, 1'b1, 1'b0, {1'b0, 16'h0000});
        send(16'h7F00, 16'h0200, 1'b0, 1'b1, {1'b1, 16'h7FFF});
        send(16'h7F00, 16'h0200, 1'b0, 1'b0, {1'b1, 16'hFE00});
        send(16'h8000, 16'h8000, 1'b0, 1'b1, {1'b1, 16'h7FFF});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 16'h0000});
        send(16'h8000, 16'h0200, 1'b0, 1'b1, {1'b1, 16'h8000});

        // Back-pressure: 8 streamed beats, downstream stalls for cycles 2-7
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(1'($urandom), 1'($urandom));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Mode isolation: modes alternate every back-to-back beat
        for (int i = 0; i < 12; i++) send_rand(1'(i), 1'(i >> 1));

        // Random traffic with random downstream readiness
        fork
            begin
                for (int i = 0; i < 60; i++) send_rand(1'($urandom), 1'($urandom));
            end
            begin
                for (int c = 0; c < 150; c++) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        // Reset with three beats in flight
        send_rand(1'b0, 1'b0);
        send_rand(1'b1, 1'b1);
        send_rand(1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0180, 16'h0200, 1'b0, 1'b0, {1'b0, 16'h0300});
        send_rand(1'b1, 1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("post_rst_drain", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fxp_mult_pipe.md
Name: fxp_mult_pipe

Overview:
Parametrised, pipelined signed fixed-point multiplier. It is the next-generation replacement for the team's combinational Q8.8 multiplier used in the autoencoder neuron datapath.
- Adds configurable word/fraction width.
- Adds per-operation rounding and saturation modes, plus an overflow flag.
- Uses a valid/ready handshake with full back-pressure, so it can sit between the weight/activation fetch logic and the accumulator.

Parameters:
- DATA_W, 16, operand and result width, two's complement; legal range 4..32.
- FRAC_W, 8, fractional bits of operands and result (Q(DATA_W-FRAC_W).FRAC_W); legal range 0..DATA_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  DATA_W  operand A, signed fixed-point.
- in_b  in  DATA_W  operand B, signed fixed-point.
- in_rnd  in  1  0 = truncate (floor, toward -inf); 1 = round half up (add 2^(FRAC_W-1) before shift).
- in_sat  in  1  0 = wrap (keep low DATA_W bits); 1 = saturate to the signed min/max.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed fixed-point product.
- out_ovf  out  1  result was out of range before wrap or saturation; valid with out_valid.

Behaviour:
- Reset is asynchronous and active-high. All stage-valid bits go to 0. out_valid=0, out_data=0, out_ovf=0. in_ready becomes 1 on the first cycle after rst deasserts.
- A reset mid-operation discards every in-flight beat; no partial result is ever emitted.
- Pipeline has 3 register stages:
  - S1: register in_a, in_b, in_rnd, in_sat.
  - S2: full signed product P, 2*DATA_W bits, with modes carried along.
  - S3: round, shift, range-check and saturate; registers out_data and out_ovf.
- Latency is 3 cycles from accept to out_valid when out_ready is held at 1. Throughput is 1 beat per cycle.
- A transfer occurs on a clock edge where valid&&ready on that interface.
- Stage k advances when its valid bit is 0 or stage k+1 advances. S3 advances when out_valid is 0 or out_ready is 1.
- in_ready = S1 advance. Bubbles collapse: in_ready=1 whenever any stage is empty, even while out_ready=0.
- The path out_ready -> in_ready is combinational; this is permitted.
- While stalled, out_data, out_ovf and all stage contents hold stable. No beat is lost or duplicated.
- Arithmetic:
  - R = P + (rnd && FRAC_W>0 ? 2^(FRAC_W-1) : 0), computed in 2*DATA_W+1 bits.
  - Q = R >>> FRAC_W (arithmetic shift).
  - ovf = 1 when Q lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat=1 and ovf: out_data = Q<0 ? 2^(DATA_W-1) (min) : 2^(DATA_W-1)-1 (max).
  - Otherwise: out_data = Q[DATA_W-1:0].
- Modes are sampled per beat at acceptance. Changing in_rnd/in_sat while beats are in flight has no effect on those beats.
- Corner case: min*min overflows; ovf=1. Saturate gives max; wrap gives the low DATA_W bits of Q.

Decomposition:
- Shared package fxp_pkg holds:
  - function fxp_max(DATA_W) and function fxp_min(DATA_W);
  - localparam PROD_W = 2*DATA_W;
  - a 2-bit mode struct/typedef {rnd, sat}, carried through the pipeline.
- One combinational sub-module, fxp_round_sat (params DATA_W, FRAC_W), implements the S3 arithmetic. It is reused later by the accumulator's output quantiser.

Test Plan (DATA_W=16, FRAC_W=8, out_ready=1 unless stated):
- Basic: a=0x0180 (1.5), b=0x0200 (2.0), rnd=0, sat=0 -> out_data=0x0300, ovf=0, out_valid exactly 3 cycles after accept. Also a=0xFF00 (-1.0), b=0x0080 (0.5) -> 0xFF80.
- Rounding:
  - a=0x0001, b=0x0080 -> rnd=0: 0x0000; rnd=1: 0x0001.
  - a=0xFFFF, b=0x0080 -> rnd=0: 0xFFFF; rnd=1: 0x0000.
- Overflow:
  - a=0x7F00, b=0x0200 -> sat=1: 0x7FFF, ovf=1; sat=0: 0xFE00, ovf=1.
  - a=0x8000, b=0x8000 -> sat=1: 0x7FFF, ovf=1.
  - a=0x8000, b=0x0200 -> sat=1: 0x8000, ovf=1.
- Back-pressure:
  - Stream 8 random beats with in_valid=1 and out_ready=0 for cycles 2-7. in_ready must drop only once all 3 stages are full.
  - out_data must stay stable while stalled.
  - All 8 results must match the golden model, in order, with no loss or duplication.
- Mode isolation: alternate rnd/sat every beat back-to-back -> each result uses its own beat's modes.
- Reset mid-stream: assert rst asynchronously (between edges) with 3 beats in flight -> out_valid=0 immediately, out_data=0. After release, only post-reset beats appear.
